uart_rx_engine: RTL
===================

# uart_rx_engine

Standalone UART receiver: deserialises an 8N1 serial stream on `rx` into parallel words, using 16x oversampling and a mid-bit sample. It is the receive end of the serial link driven by the team's UART transmit path. It presents each received word through a valid/ready holding register and flags framing errors, overruns and (optionally) parity errors. It sits between the external `rx` pin and any consumer FIFO or controller.

## Interface
- `WIDTH`, 8: data bits per frame.
- `BAUD_DIV`, 16: clock cycles per oversample tick. One bit time is 16 ticks, i.e. 16*BAUD_DIV clocks. Legal range is >= 1.
- `PARITY_ODD`, 0: parity sense, 1 = odd. Only used with `UART_RX_PARITY_EN`.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `rx`  in  1  asynchronous serial input; idles high.
- `rx_ready`  in  1  consumer accepts the held word.
- `dout`  out  WIDTH  received word, LSB first on the line.
- `rx_valid`  out  1  `dout` holds an unconsumed word.
- `framing_error`  out  1  one-cycle pulse: stop bit sampled 0.
- `overrun`  out  1  one-cycle pulse: a frame completed while the holding register was full.
- `parity_error`  out  1  one-cycle pulse: parity mismatch. Tied 0 when the macro is absent.
- `busy`  out  1  FSM not in IDLE.

## Operation
- **Input synchroniser:** `rx` passes through a 2-FF synchroniser whose flops reset to 1. All decisions use the synchronised bit.
- **Tick generator:** free-running counter 0..BAUD_DIV-1. `tick` fires when the count equals BAUD_DIV-1.
- **Sample counter:** 4-bit, 0..15, advanced on `tick` only.
- **IDLE:** on a tick with sync rx = 0, go to START and clear the sample counter.
- **START:** at sample count 7 (mid-bit):
  - rx = 0: go to DATA, clear the sample counter and bit index.
  - rx = 1: glitch. Return to IDLE with no output.
- **DATA:** at sample count 15 (one bit time after the previous mid-point), shift rx into the MSB of the shift register (LSB-first frame). After WIDTH bits, go to PARITY if enabled, otherwise STOP.
- **PARITY** (macro only): sample the parity bit. Compare it against XOR of the data, inverted when PARITY_ODD = 1. Store the mismatch result, then go to STOP.
- **STOP:** sample at count 15.
  - rx = 1 and no parity mismatch: deliver the word, go to IDLE.
  - rx = 1 and parity mismatch: pulse `parity_error`, discard the word, go to IDLE.
  - rx = 0: pulse `framing_error`, discard the word, go to BREAK.
- **BREAK:** wait until sync rx = 1, then go to IDLE. This prevents a held-low line from retriggering.
- **Deliver:**
  - If `rx_valid` = 0, or `rx_valid && rx_ready` in the same cycle: load `dout` and set `rx_valid`.
  - Otherwise: pulse `overrun`, drop the new word, and keep the old `dout`/`rx_valid`.
- **Consume:** `rx_valid && rx_ready` clears `rx_valid` the next cycle, unless a delivery occurs in that same cycle.
- `dout` is stable while `rx_valid` = 1.

## Timing
- **Reset values:** `dout` = 0, `rx_valid` = 0, all error pulses 0, `busy` = 0, FSM in IDLE, tick and sample counters 0, synchroniser = 1.
- **Reset mid-frame:** abort immediately, with no output or error pulse.
- **Start detection:** resolution is one tick; synchroniser latency is 2 clocks.
- **Delivery latency:** `rx_valid` rises 1 clock after the stop-bit sample tick, which is about 9.5 bit times (10.5 with parity) after the start edge.
- **Error pulses:** `framing_error`, `parity_error` and `overrun` are each high for exactly 1 clock, in the cycle where `rx_valid` would have risen.
- **`busy`:** high from the START entry cycle until the FSM returns to IDLE.
- **Back-to-back frames:** the receiver is ready for a new start bit from the first IDLE cycle after STOP. No inter-frame gap is needed beyond the stop bit.

## Configuration
- Macro `UART_RX_PARITY_EN`.
- **Defined:** frame is start + WIDTH data + 1 parity + 1 stop. The PARITY state exists and `parity_error` is live.
- **Undefined:** frame is 8N1-style (start + WIDTH + stop). There is no PARITY state, `parity_error` is constant 0, and `PARITY_ODD` is ignored.

## Test plan
All scenarios use BAUD_DIV = 4 (64 clocks per bit).
- **Single word:** `rx_ready` = 1, send 0xA5 → one `rx_valid` cycle with `dout` = 0xA5. No error pulses. `busy` returns to 0.
- **Start glitch:** drive `rx` low for 16 clocks, then high → no `rx_valid`, no errors, FSM back in IDLE within 1 bit time.
- **Framing error and recovery:** send 0x3C with stop bit 0 → one `framing_error` pulse, `rx_valid` stays 0. Hold `rx` low 200 clocks, release, then send 0x11 → `dout` = 0x11 valid.
- **Overrun:** `rx_ready` = 0, send 0x01 then 0x02 → `dout` = 0x01 held, one `overrun` pulse at the second stop sample. Then raise `rx_ready` → `rx_valid` clears the next cycle.
- **Reset mid-frame:** assert `rst` during data bit 3 of 0xFF → all outputs 0. Then send 0x5A → received exactly once, correct.
- **Parity (macro defined, PARITY_ODD = 0):** send 0x07 with parity bit 0 → `parity_error` pulse, no `rx_valid`. Send 0x07 with parity bit 1 → `dout` = 0x07 valid.

Source files
------------

// File: rtl/uart_rx_engine.sv
// -----------------------------------------------------------------------------
// uart_rx_engine
//
// Standalone UART receiver. Deserialises a start + WIDTH data (+ optional
// parity) + stop frame on rx into parallel words using 16x oversampling and a
// mid-bit sample. Each received word is presented through a valid/ready
// holding register; framing errors, overruns and parity errors are flagged
// with one-cycle pulses.
//
// Optional feature: define UART_RX_PARITY_EN to add a parity bit between the
// last data bit and the stop bit (sense selected by PARITY_ODD). Without the
// macro the frame is 8N1-style and parity_error is tied low.
//
// Parameters:
//   WIDTH       data bits per frame
//   BAUD_DIV    clocks per oversample tick (one bit = 16 ticks), >= 1
//   PARITY_ODD  1 = odd parity, 0 = even (only with UART_RX_PARITY_EN)
//
// Ports:
//   clk            system clock
//   rst            synchronous active-high reset
//   rx             asynchronous serial input, idles high
//   rx_ready       consumer accepts the held word
//   dout           received word (LSB first on the line)
//   rx_valid       dout holds an unconsumed word
//   framing_error  1-cycle pulse: stop bit sampled low
//   overrun        1-cycle pulse: frame completed while holding register full
//   parity_error   1-cycle pulse: parity mismatch (0 without the macro)
//   busy           receiver FSM not idle
// -----------------------------------------------------------------------------
module uart_rx_engine #(
    parameter int WIDTH      = 8,
    parameter int BAUD_DIV   = 16,
    parameter int PARITY_ODD = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rx,
    input  logic             rx_ready,
    output logic [WIDTH-1:0] dout,
    output logic             rx_valid,
    output logic             framing_error,
    output logic             overrun,
    output logic             parity_error,
    output logic             busy
);

    localparam int TW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    // Reject nonsensical configurations at elaboration.
    if (WIDTH < 1 || BAUD_DIV < 1 || (PARITY_ODD != 0 && PARITY_ODD != 1)) begin : g_bad_params
        $error("uart_rx_engine: illegal parameter value");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_BREAK
    } state_e;

    state_e           state_q;
    logic             rx_meta_q, rx_sync_q;
    logic [TW-1:0]    tick_cnt_q, tick_cnt_d;
    logic             tick;
    logic [3:0]       sample_cnt_q;
    logic [IW-1:0]    bit_idx_q;
    logic [WIDTH-1:0] shift_q;
    logic [WIDTH-1:0] dout_q;
    logic             rx_valid_q;
    logic             framing_q;
    logic             overrun_q;
`ifdef UART_RX_PARITY_EN
    logic             par_bad_q;
    logic             par_err_q;
`endif

    assign tick       = (tick_cnt_q == TW'(BAUD_DIV - 1));
    assign tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);

    // Synchroniser and free-running tick divider.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours (the two sync stages rely
    // on this to stay two separate stages).
    always_ff @(posedge clk) begin
        if (rst) begin
            // Reset to the idle line level so reset never looks like a start bit.
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            tick_cnt_q <= '0;
        end else begin
            rx_meta_q  <= rx;
            rx_sync_q  <= rx_meta_q;
            tick_cnt_q <= tick_cnt_d;
        end
    end

    // Receive FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            sample_cnt_q <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            dout_q       <= '0;
            rx_valid_q   <= 1'b0;
            framing_q    <= 1'b0;
            overrun_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q    <= 1'b0;
            par_err_q    <= 1'b0;
`endif
        end else begin
            // Error flags are pulses: cleared every cycle unless re-asserted.
            framing_q <= 1'b0;
            overrun_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_err_q <= 1'b0;
`endif
            // Consume; a delivery in the STOP branch below overrides this.
            if (rx_valid_q && rx_ready) begin
                rx_valid_q <= 1'b0;
            end

            case (state_q)
                S_IDLE: begin
                    if (tick && !rx_sync_q) begin
                        state_q      <= S_START;
                        sample_cnt_q <= '0;
                    end
                end

                S_START: begin
                    if (tick) begin
                        if (sample_cnt_q == 4'd7) begin
                            // Mid start bit: still low means a real frame.
                            if (!rx_sync_q) begin
                                state_q      <= S_DATA;
                                sample_cnt_q <= '0;
                                bit_idx_q    <= '0;
                            end else begin
                                state_q <= S_IDLE;
                            end
                        end else begin
                            sample_cnt_q <= sample_cnt_q + 4'd1;
                        end
                    end
                end

                S_DATA: begin
                    if (tick) begin
                        // 4-bit counter wraps 15 -> 0, so every bit is 16 ticks.
                        sample_cnt_q <= sample_cnt_q + 4'd1;
                        if (sample_cnt_q == 4'd15) begin
                            shift_q   <= {rx_sync_q, shift_q[WIDTH-1:1]};
                            bit_idx_q <= bit_idx_q + IW'(1);
                            if (bit_idx_q == IW'(WIDTH - 1)) begin
`ifdef UART_RX_PARITY_EN
                                state_q <= S_PARITY;
`else
                                state_q <= S_STOP;
`endif
                            end
                        end
                    end
                end

`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (tick) begin
                        sample_cnt_q <= sample_cnt_q + 4'd1;
                        if (sample_cnt_q == 4'd15) begin
                            par_bad_q <= rx_sync_q ^ (^shift_q) ^ (PARITY_ODD != 0);
                            state_q   <= S_STOP;
                        end
                    end
                end
`endif

                S_STOP: begin
                    if (tick) begin
                        sample_cnt_q <= sample_cnt_q + 4'd1;
                        if (sample_cnt_q == 4'd15) begin
                            if (!rx_sync_q) begin
                                framing_q <= 1'b1;
                                state_q   <= S_BREAK;
                            end else begin
                                state_q <= S_IDLE;
`ifdef UART_RX_PARITY_EN
                                if (par_bad_q) begin
                                    par_err_q <= 1'b1;
                                end else
`endif
                                if (!rx_valid_q || rx_ready) begin
                                    dout_q     <= shift_q;
                                    rx_valid_q <= 1'b1;
                                end else begin
                                    overrun_q <= 1'b1;
                                end
                            end
                        end
                    end
                end

                S_BREAK: begin
                    // Hold off until the line returns high so a stuck-low
                    // line cannot retrigger a frame.
                    if (rx_sync_q) begin
                        state_q <= S_IDLE;
                    end
                end

                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign dout          = dout_q;
    assign rx_valid      = rx_valid_q;
    assign framing_error = framing_q;
    assign overrun       = overrun_q;
    assign busy          = (state_q != S_IDLE);
`ifdef UART_RX_PARITY_EN
    assign parity_error  = par_err_q;
`else
    assign parity_error  = 1'b0;
`endif

endmodule
